// File: rtl/rc4_prga_decryptor.sv
// -----------------------------------------------------------------------------
// rc4_prga_decryptor
//
// Runs the RC4 pseudo-random generation algorithm over an S array that has
// already been key-scheduled into an external synchronous S-RAM. Each
// keystream byte is XORed with one byte of an encrypted-message ROM and
// written to a result RAM. Every decrypted byte is classified as plaintext
// (lower-case letter or space). Any other byte raises `invalid` and, when
// ABORT_ON_INVALID is set, ends the run early.
//
// One byte takes exactly nine cycles:
//   RD_SI -> WAIT_SI -> RD_SJ -> WAIT_SJ -> WR_I -> WR_J -> RD_F -> WAIT_F
//   -> WR_DEC
// Both RAMs have a one-cycle read latency. An address driven in one cycle
// returns its data at the end of the next cycle, so each read state is
// followed by a WAIT state that captures the data.
//
// Ports
//   clk              : sole clock, rising edge
//   reset            : synchronous, active-low
//   start            : run request; only a rising edge is acted on
//   finished         : high in DONE until the next start edge
//   invalid          : a decrypted byte fell outside the plaintext set
//   s_address        : S-RAM address
//   s_ram_in         : S-RAM write data
//   s_write_enable   : S-RAM write enable
//   s_ram_out        : S-RAM read data
//   msg_address      : encrypted-message ROM address
//   msg_ram_out      : encrypted-message ROM read data
//   dec_address      : result RAM address
//   dec_data         : result RAM write data
//   dec_write_enable : result RAM write enable
// -----------------------------------------------------------------------------
module rc4_prga_decryptor #(
   parameter int RAM_WIDTH        = 8,
   parameter int RAM_LENGTH       = 8,
   parameter int MSG_LENGTH       = 32,
   parameter int MSG_ADDR_WIDTH   = 5,
   parameter int ABORT_ON_INVALID = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic                      finished,
   output logic                      invalid,
   input  logic [RAM_WIDTH-1:0]      s_ram_out,
   output logic [RAM_LENGTH-1:0]     s_address,
   output logic [RAM_WIDTH-1:0]      s_ram_in,
   output logic                      s_write_enable,
   output logic [MSG_ADDR_WIDTH-1:0] msg_address,
   input  logic [RAM_WIDTH-1:0]      msg_ram_out,
   output logic [MSG_ADDR_WIDTH-1:0] dec_address,
   output logic [RAM_WIDTH-1:0]      dec_data,
   output logic                      dec_write_enable
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] RD_SI   = 4'd1;
   localparam logic [3:0] WAIT_SI = 4'd2;
   localparam logic [3:0] RD_SJ   = 4'd3;
   localparam logic [3:0] WAIT_SJ = 4'd4;
   localparam logic [3:0] WR_I    = 4'd5;
   localparam logic [3:0] WR_J    = 4'd6;
   localparam logic [3:0] RD_F    = 4'd7;
   localparam logic [3:0] WAIT_F  = 4'd8;
   localparam logic [3:0] WR_DEC  = 4'd9;
   localparam logic [3:0] DONE    = 4'd10;

   localparam logic [MSG_ADDR_WIDTH-1:0] LAST_K = MSG_ADDR_WIDTH'(MSG_LENGTH - 1);

   logic [3:0]                state;
   logic [RAM_LENGTH-1:0]     i;
   logic [RAM_LENGTH-1:0]     j;
   logic [MSG_ADDR_WIDTH-1:0] k;
   logic [RAM_WIDTH-1:0]      si;
   logic [RAM_WIDTH-1:0]      sj;
   logic [RAM_WIDTH-1:0]      f;
   logic [RAM_WIDTH-1:0]      enc;
   logic                      invalid_q;
   logic                      start_q;

   logic                      start_rise;
   logic [RAM_WIDTH-1:0]      dec_byte;
   logic                      dec_plain;

   function automatic logic is_plain(input logic [RAM_WIDTH-1:0] b);
      return ((b >= RAM_WIDTH'('h61)) && (b <= RAM_WIDTH'('h7A))) ||
             (b == RAM_WIDTH'('h20));
   endfunction

   assign start_rise = start & ~start_q;
   assign dec_byte   = f ^ enc;
   assign dec_plain  = is_plain(dec_byte);

   // i, j and the F index are RAM_LENGTH bits wide, so the mod-256 of RC4
   // falls out of plain wrap-around.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of the others regardless of order.
   always_ff @(posedge clk) begin
      // The start sampler tracks start even during reset, so a level held
      // through reset release is not mistaken for a fresh edge.
      start_q <= start;
      if (!reset) begin
         state     <= IDLE;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         si        <= '0;
         sj        <= '0;
         f         <= '0;
         enc       <= '0;
         invalid_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_rise) begin
                  i         <= RAM_LENGTH'(1);
                  j         <= '0;
                  k         <= '0;
                  invalid_q <= 1'b0;
                  state     <= RD_SI;
               end else if (state == IDLE) begin
                  i <= '0;
                  j <= '0;
                  k <= '0;
               end
            end
            RD_SI:   state <= WAIT_SI;
            WAIT_SI: begin
               si    <= s_ram_out;
               j     <= j + RAM_LENGTH'(s_ram_out);
               state <= RD_SJ;
            end
            RD_SJ:   state <= WAIT_SJ;
            WAIT_SJ: begin
               sj    <= s_ram_out;
               state <= WR_I;
            end
            WR_I:    state <= WR_J;
            WR_J:    state <= RD_F;
            RD_F:    state <= WAIT_F;
            WAIT_F: begin
               f     <= s_ram_out;
               enc   <= msg_ram_out;
               state <= WR_DEC;
            end
            WR_DEC: begin
               k <= k + MSG_ADDR_WIDTH'(1);
               i <= i + RAM_LENGTH'(1);
               if (!dec_plain) invalid_q <= 1'b1;
               if ((!dec_plain && (ABORT_ON_INVALID != 0)) || (k == LAST_K))
                  state <= DONE;
               else
                  state <= RD_SI;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are decoded from the state and forced to zero while reset is
   // low. A reset that lands mid-run therefore blocks the write that would
   // otherwise hit the RAM on that same edge.
   // NOTE: every output gets a default before the case, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      finished         = 1'b0;
      invalid          = 1'b0;
      s_address        = '0;
      s_ram_in         = '0;
      s_write_enable   = 1'b0;
      msg_address      = '0;
      dec_address      = '0;
      dec_data         = '0;
      dec_write_enable = 1'b0;
      if (reset) begin
         finished    = (state == DONE);
         invalid     = invalid_q;
         // The message read is issued in RD_SI. Holding k on the ROM for the
         // whole byte lets WAIT_F pick up the data without a second request.
         msg_address = k;
         case (state)
            RD_SI: s_address = i;
            RD_SJ: s_address = j;
            WR_I: begin
               s_address      = i;
               s_ram_in       = sj;
               s_write_enable = 1'b1;
            end
            WR_J: begin
               s_address      = j;
               s_ram_in       = si;
               s_write_enable = 1'b1;
            end
            RD_F:  s_address = RAM_LENGTH'(si) + RAM_LENGTH'(sj);
            WR_DEC: begin
               dec_address      = k;
               dec_data         = dec_byte;
               dec_write_enable = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/rc4_prga_decryptor.md
RC4_PRGA_DECRYPTOR -- requirements
Module: rc4_prga_decryptor

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, data width of the S, message and result memories.
REQ-002 SHALL have parameter RAM_LENGTH, default 8, S-RAM address width (256 entries).
REQ-003 SHALL have parameter MSG_LENGTH, default 32, number of message bytes to decrypt.
REQ-004 SHALL have parameter MSG_ADDR_WIDTH, default 5, message and result address width.
REQ-005 SHALL have parameter ABORT_ON_INVALID, default 1; 1 means stop at the first non-plaintext byte.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port start  input  1  request; only its rising edge is acted on.
REQ-009 SHALL have port finished  output  1  run complete.
REQ-010 SHALL have port invalid  output  1  a decrypted byte fell outside the plaintext set.
REQ-011 SHALL have port s_ram_out  input  RAM_WIDTH  S-RAM read data.
REQ-012 SHALL have ports s_address  output  RAM_LENGTH, s_ram_in  output  RAM_WIDTH, s_write_enable  output  1  S-RAM access.
REQ-013 SHALL have ports msg_address  output  MSG_ADDR_WIDTH, msg_ram_out  input  RAM_WIDTH  encrypted-message ROM.
REQ-014 SHALL have ports dec_address  output  MSG_ADDR_WIDTH, dec_data  output  RAM_WIDTH, dec_write_enable  output  1  result RAM.

Function
REQ-015 SHALL implement the RC4 PRGA over an S array already shuffled in S-RAM: for k = 0..MSG_LENGTH-1: i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[(S[i]+S[j])]; dec[k]=f XOR msg[k].
REQ-016 SHALL perform all i, j and index arithmetic in 8 bits, so mod 256 comes from wrap-around (i=255+1 -> 0).
REQ-017 SHALL assume both RAMs are synchronous: an address presented in cycle N yields data sampled at the end of cycle N+1.
REQ-018 SHALL use states IDLE, RD_SI, WAIT_SI, RD_SJ, WAIT_SJ, WR_I, WR_J, RD_F, WAIT_F, WR_DEC, DONE.
REQ-019 IDLE: i=0, j=0, k=0, all write enables 0; on a start rising edge, SHALL set i=1 and go to RD_SI.
REQ-020 RD_SI SHALL drive s_address=i and msg_address=k, and msg_address SHALL hold k until WR_DEC.
REQ-021 WAIT_SI SHALL capture si=s_ram_out and set j=j+si.
REQ-022 RD_SJ SHALL drive s_address=j (the updated j).
REQ-023 WAIT_SJ SHALL capture sj.
REQ-024 WR_I SHALL drive s_address=i, s_ram_in=sj, s_write_enable=1.
REQ-025 WR_J SHALL drive s_address=j, s_ram_in=si, s_write_enable=1.
REQ-026 RD_F SHALL drive s_address=si+sj (8-bit).
REQ-027 WAIT_F SHALL capture f=s_ram_out and enc=msg_ram_out.
REQ-028 WR_DEC SHALL drive dec_address=k, dec_data=f^enc, dec_write_enable=1, then increment k and i.
REQ-029 Each byte SHALL take exactly 9 cycles (RD_SI..WR_DEC), with no extra cycles between bytes.
REQ-030 When i=j, the two writes SHALL both occur (same address, same value), leaving S unchanged.
REQ-031 A byte is plaintext iff 0x61<=byte<=0x7A or byte==0x20.
REQ-032 A non-plaintext byte SHALL still be written; invalid SHALL be set in the following cycle and held until the next start edge.
REQ-033 If ABORT_ON_INVALID=1, after WR_DEC of a non-plaintext byte the block SHALL go to DONE; otherwise it SHALL continue.
REQ-034 After WR_DEC of k=MSG_LENGTH-1, the block SHALL go to DONE.
REQ-035 DONE SHALL hold finished=1 with all write enables 0 until a start rising edge, which clears finished and invalid and re-enters the IDLE initialisation then RD_SI.
REQ-036 Start edges in any state other than IDLE or DONE SHALL be ignored.
REQ-037 Write enables SHALL never be asserted outside WR_I, WR_J and WR_DEC.

Reset
REQ-038 While reset=0 at a clock edge, the block SHALL set state=IDLE and i=j=k=si=sj=f=0.
REQ-039 While reset=0 at a clock edge, every output (finished, invalid, all addresses, data and write enables) SHALL be 0.
REQ-040 Reset mid-run SHALL abort immediately, with no further writes and no restoration of S-RAM or result RAM; a new run requires a start edge after reset is released.

Verification
REQ-041 S[x]=x for all x, msg all 0x00, ABORT_ON_INVALID=0 -> dec[0]=0x02, dec[1]=0x05; S[2]=0x03 and S[3]=0x02 after byte 1.
REQ-042 Same S with msg[0]=0x63, msg[1]=0x60 -> dec[0]=0x61, dec[1]=0x65, invalid stays 0 through byte 1.
REQ-043 S[x]=x, msg all 0x00, ABORT_ON_INVALID=1 -> exactly one dec write (0x02 at address 0), then invalid=1 and finished=1, with finished rising 10 cycles after the start-edge cycle.
REQ-044 Full run with MSG_LENGTH=32 against a software RC4 model (key 0x000249, message from the ROM) -> all 32 bytes match the model, finished rises 1+9*32 cycles after the start edge, exactly 64 S writes and 32 dec writes.
REQ-045 reset=0 asserted in WR_J of byte 3 -> the next cycle shows state IDLE and all outputs 0; the run does not resume until a new start edge after reset is released.
REQ-046 Start toggled repeatedly during a run -> no effect; a start edge in DONE -> finished drops the next cycle and a new run begins with i=1, j=0.
